lector_banco: RTL and testbench

Sequential reader for the 32×32 register file. On a start command it walks an address range through one register-file read port, then streams each word with its address over a valid/ready handshake. It is used for register dumps to the debug/trace path and for state save, and it sits between the register file's read port and any streaming consumer.

---
 rtl/lector_banco_pkg.sv | 15 +
 rtl/lector_banco_if.sv | 28 ++
 rtl/lector_banco.sv | 138 +++++++++++++
 tb/tb_lector_banco.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lector_banco_pkg.sv
// Shared types and default sizes for the sequential register-file reader.
package lector_banco_pkg;

    typedef enum logic [1:0] {
        REPOSO,
        LEER,
        ENVIAR,
        TERMINAR
    } estado_t;

    localparam int unsigned ANCHO_DEF  = 32;
    localparam int unsigned NREG_DEF   = 32;
    localparam int unsigned ADDR_W_DEF = 5;

endpackage

// File: rtl/lector_banco_if.sv
// Output stream of the reader: word, its address and a valid/ready handshake.
interface lector_banco_if
    import lector_banco_pkg::*;
#(
    parameter int unsigned ANCHO  = ANCHO_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic [ANCHO-1:0]  sal_dato;
    logic [ADDR_W-1:0] sal_dir;
    logic              sal_valid;
    logic              sal_ready;

    modport master (
        output sal_dato,
        output sal_dir,
        output sal_valid,
        input  sal_ready
    );

    modport slave (
        input  sal_dato,
        input  sal_dir,
        input  sal_valid,
        output sal_ready
    );

endinterface

// File: rtl/lector_banco.sv
// Sequential register-file reader: walks dir_ini..dir_fin (inclusive, wrapping
// modulo NREG) through one read port and streams each word with its address.
// Optional running checksum output 'suma' enabled by defining LECTOR_SUMA_EN.
module lector_banco
    import lector_banco_pkg::*;
#(
    parameter int unsigned ANCHO  = ANCHO_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inicio,
    input  logic [ADDR_W-1:0] dir_ini,
    input  logic [ADDR_W-1:0] dir_fin,
    output logic [ADDR_W-1:0] dl,
    input  logic [ANCHO-1:0]  q,
    lector_banco_if.master    sal,
    output logic              ocupado,
`ifdef LECTOR_SUMA_EN
    output logic [ANCHO-1:0]  suma,
`endif
    output logic              fin
);

    // The pointer wraps by plain overflow, so NREG must fill the address space.
    if (NREG != (32'd1 << ADDR_W)) begin : g_param_chk
        $error("lector_banco: NREG must equal 2**ADDR_W");
    end

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] ult_q, ult_d;
    logic [ANCHO-1:0]  dato_q, dato_d;
    logic [ADDR_W-1:0] dir_q, dir_d;
    logic              valid_q, valid_d;
    logic              ocupado_q, ocupado_d;
    logic              acepta;

    assign acepta = valid_q && sal.sal_ready;

    // Next-state logic: load range on start, capture a word, wait for handshake.
    always_comb begin
        estado_d  = estado_q;
        ptr_d     = ptr_q;
        ult_d     = ult_q;
        dato_d    = dato_q;
        dir_d     = dir_q;
        valid_d   = valid_q;
        ocupado_d = ocupado_q;
        unique case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    ptr_d     = dir_ini;
                    ult_d     = dir_fin;
                    ocupado_d = 1'b1;
                    estado_d  = LEER;
                end
            end
            LEER: begin
                dato_d   = q;
                dir_d    = ptr_q;
                valid_d  = 1'b1;
                estado_d = ENVIAR;
            end
            ENVIAR: begin
                if (acepta) begin
                    valid_d = 1'b0;
                    if (ptr_q == ult_q) begin
                        estado_d = TERMINAR;
                    end else begin
                        ptr_d    = ptr_q + ADDR_W'(1);
                        estado_d = LEER;
                    end
                end
            end
            TERMINAR: begin
                ocupado_d = 1'b0;
                estado_d  = REPOSO;
            end
            default: estado_d = REPOSO;
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= REPOSO;
            ptr_q     <= '0;
            ult_q     <= '0;
            dato_q    <= '0;
            dir_q     <= '0;
            valid_q   <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            ptr_q     <= ptr_d;
            ult_q     <= ult_d;
            dato_q    <= dato_d;
            dir_q     <= dir_d;
            valid_q   <= valid_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign dl            = ptr_q;
    assign sal.sal_dato  = dato_q;
    assign sal.sal_dir   = dir_q;
    assign sal.sal_valid = valid_q;
    assign ocupado       = ocupado_q;
    assign fin           = (estado_q == TERMINAR);

`ifdef LECTOR_SUMA_EN
    logic [ANCHO-1:0] suma_q, suma_d;

    // Checksum cleared on start, accumulates every accepted word.
    always_comb begin
        suma_d = suma_q;
        if (estado_q == REPOSO && inicio) begin
            suma_d = '0;
        end else if (estado_q == ENVIAR && acepta) begin
            suma_d = suma_q + dato_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            suma_q <= '0;
        end else begin
            suma_q <= suma_d;
        end
    end

    assign suma = suma_q;
`endif

endmodule

// File: tb/tb_lector_banco.sv
// Self-checking bench for lector_banco: a behavioural register file drives the
// read port and the expected word stream is computed from the range rules.
// Define LECTOR_SUMA_EN to also check the checksum output.
module tb_lector_banco;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inicio;
    logic [4:0]  dir_ini;
    logic [4:0]  dir_fin;
    logic [4:0]  dl;
    logic [31:0] q;
    logic        ocupado;
    logic        fin;
`ifdef LECTOR_SUMA_EN
    logic [31:0] suma;
`endif

    logic [31:0] mem [32];

    int errores = 0;
    int checks  = 0;

    lector_banco_if #(.ANCHO(32), .ADDR_W(5)) bus ();

    lector_banco #(.ANCHO(32), .NREG(32), .ADDR_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (inicio),
        .dir_ini (dir_ini),
        .dir_fin (dir_fin),
        .dl      (dl),
        .q       (q),
        .sal     (bus),
        .ocupado (ocupado),
`ifdef LECTOR_SUMA_EN
        .suma    (suma),
`endif
        .fin     (fin)
    );

    always #5 clk = ~clk;

    // Combinational register-file read port.
    assign q = mem[dl];

    task automatic comprobar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        checks++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: obtenido=%0h esperado=%0h", tag, obs, esp);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    // modo 0: ready always high; 1: random ready; 2: ready low 5 cycles on word 2.
    // pulso: raise inicio mid-transfer and in the FIN cycle, both must be ignored.
    task automatic volcado(input int ini, input int ult, input int modo, input bit pulso);
        int          n_esp;
        int          recibidos;
        int          n;
        int          espera;
        int          a;
        bit          r;
        bit          prev_v;
        bit          prev_hs;
        logic [31:0] prev_d;
        logic [4:0]  prev_a;
        logic [31:0] suma_esp;

        n_esp    = ((ult - ini + 32) % 32) + 1;
        suma_esp = '0;
        for (int i = 0; i < n_esp; i++) suma_esp += mem[(ini + i) % 32];

        dir_ini = 5'(ini);
        dir_fin = 5'(ult);
        inicio  = 1'b1;
        ciclo();
        inicio = 1'b0;
        comprobar("ocupado_ini", ocupado, 1);
        comprobar("dl_ini", dl, ini);
        comprobar("valid_ini", bus.sal_valid, 0);

        n = 0; recibidos = 0; espera = 0; prev_v = 0; prev_hs = 0;
        prev_d = '0; prev_a = '0;
        while (n < 400) begin
            if (fin === 1'b1) break;
            inicio = (pulso && n == 3);
            if (prev_v && !prev_hs) begin
                comprobar("valid_estable", bus.sal_valid, 1);
                comprobar("dato_estable", bus.sal_dato, prev_d);
                comprobar("dir_estable", bus.sal_dir, prev_a);
            end
            case (modo)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: begin
                    r = 1'b1;
                    if (bus.sal_valid && recibidos == 1 && espera < 5) begin
                        r = 1'b0;
                        espera++;
                    end
                end
            endcase
            bus.sal_ready = r;
            prev_v  = bus.sal_valid;
            prev_d  = bus.sal_dato;
            prev_a  = bus.sal_dir;
            prev_hs = bus.sal_valid && r;
            if (bus.sal_valid && r) begin
                if (recibidos < n_esp) begin
                    a = (ini + recibidos) % 32;
                    comprobar("dir", bus.sal_dir, a);
                    comprobar("dato", bus.sal_dato, mem[a]);
                end else begin
                    comprobar("palabra_extra", recibidos + 1, n_esp);
                end
                recibidos++;
            end
            ciclo();
            n++;
        end
        inicio = 1'b0;
        comprobar("fin_visto", fin, 1);
        comprobar("palabras", recibidos, n_esp);
        if (modo == 0) comprobar("ciclos_fin", n, 2 * n_esp);
        if (modo == 2) comprobar("espera", espera, 5);
        comprobar("ocupado_en_fin", ocupado, 1);
        comprobar("valid_en_fin", bus.sal_valid, 0);
`ifdef LECTOR_SUMA_EN
        comprobar("suma", suma, suma_esp);
`endif
        inicio = pulso;
        ciclo();
        inicio = 1'b0;
        comprobar("fin_un_ciclo", fin, 0);
        comprobar("ocupado_tras_fin", ocupado, 0);
`ifdef LECTOR_SUMA_EN
        comprobar("suma_estable", suma, suma_esp);
`endif
    endtask

    initial begin
        rst_n = 1'b0; inicio = 1'b0; dir_ini = '0; dir_fin = '0;
        bus.sal_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
        ciclo();
        ciclo();
        comprobar("rst_dl", dl, 0);
        comprobar("rst_dato", bus.sal_dato, 0);
        comprobar("rst_dir", bus.sal_dir, 0);
        comprobar("rst_valid", bus.sal_valid, 0);
        comprobar("rst_ocupado", ocupado, 0);
        comprobar("rst_fin", fin, 0);
`ifdef LECTOR_SUMA_EN
        comprobar("rst_suma", suma, 0);
`endif
        rst_n = 1'b1;
        ciclo();

        volcado(0, 31, 0, 0);   // full dump
        volcado(30, 1, 0, 0);   // wrap 30,31,0,1
        volcado(17, 17, 0, 0);  // single word
        volcado(3, 8, 2, 0);    // backpressure on second word
        volcado(10, 15, 0, 1);  // inicio ignored while busy and during FIN

        // Reset during word 3 of 10.
        dir_ini = 5'd0; dir_fin = 5'd9; bus.sal_ready = 1'b1;
        inicio = 1'b1;
        ciclo();
        inicio = 1'b0;
        for (int i = 0; i < 5; i++) ciclo();
        comprobar("palabra3_dir", bus.sal_dir, 2);
        comprobar("palabra3_valid", bus.sal_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        comprobar("rstmid_dl", dl, 0);
        comprobar("rstmid_dato", bus.sal_dato, 0);
        comprobar("rstmid_dir", bus.sal_dir, 0);
        comprobar("rstmid_valid", bus.sal_valid, 0);
        comprobar("rstmid_ocupado", ocupado, 0);
        comprobar("rstmid_fin", fin, 0);
        for (int i = 0; i < 3; i++) begin
            ciclo();
            comprobar("rstmid_sin_fin", fin, 0);
        end
        rst_n = 1'b1;
        ciclo();
        comprobar("post_rst_ocupado", ocupado, 0);
        volcado(5, 7, 0, 0);

        // Checksum range 2..4 holding 5, 7, 9.
        mem[2] = 32'd5; mem[3] = 32'd7; mem[4] = 32'd9;
        volcado(2, 4, 1, 0);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            volcado(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1,
                    1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule
